// File: rtl/retry_pkg.sv
// Shared types and defaults for the link-layer local retry state machine.
package retry_pkg;

  typedef enum logic [2:0] {
    NORMAL     = 3'd0,
    LLRREQ     = 3'd1,
    IDLE       = 3'd2,
    PHY_REINIT = 3'd3,
    ABORT      = 3'd4
  } lrsm_state_e;

  localparam int          CNT_W_DEF         = 5;
  localparam int          TMR_W_DEF         = 13;
  localparam logic [3:0]  PL_ACTIVE_STS_DEF = 4'h1;

endpackage

// File: rtl/retry_local_fsm_if.sv
// Signal bundle between unpacker/controller/register file and the local retry FSM.
interface retry_local_fsm_if #(
  parameter int CNT_W = 5,
  parameter int TMR_W = 13
);
  logic             i_pl_lnk_up;
  logic [3:0]       i_pl_state_sts;
  logic             unpacker_valid_sig;
  logic             unpacker_valid_crc;
  logic             unpacker_ack_seq_flag;
  logic             controller_req_sent_flag;
  logic             controller_inc_time_out_retry;
  logic [CNT_W-1:0] i_register_file_retry_threshold;
  logic [CNT_W-1:0] i_register_file_reinit_threshold;
  logic [TMR_W-1:0] i_register_file_retry_timeout_max_transfers;
  logic             retry_send_req_seq;
  logic             retry_phy_reinit_req;
  logic             retry_link_failure_sig;
  logic             discard_received_flits;
  logic [CNT_W-1:0] retry_num_retry;
  logic [CNT_W-1:0] retry_num_phy_reinit;
  logic             Retry_Threshold_hit;
  logic             REINIT_Threshold_hit;
  logic [2:0]       retry_lrsm_state;

  modport slave (
    input  i_pl_lnk_up, i_pl_state_sts, unpacker_valid_sig, unpacker_valid_crc,
           unpacker_ack_seq_flag, controller_req_sent_flag, controller_inc_time_out_retry,
           i_register_file_retry_threshold, i_register_file_reinit_threshold,
           i_register_file_retry_timeout_max_transfers,
    output retry_send_req_seq, retry_phy_reinit_req, retry_link_failure_sig,
           discard_received_flits, retry_num_retry, retry_num_phy_reinit,
           Retry_Threshold_hit, REINIT_Threshold_hit, retry_lrsm_state
  );

  modport master (
    output i_pl_lnk_up, i_pl_state_sts, unpacker_valid_sig, unpacker_valid_crc,
           unpacker_ack_seq_flag, controller_req_sent_flag, controller_inc_time_out_retry,
           i_register_file_retry_threshold, i_register_file_reinit_threshold,
           i_register_file_retry_timeout_max_transfers,
    input  retry_send_req_seq, retry_phy_reinit_req, retry_link_failure_sig,
           discard_received_flits, retry_num_retry, retry_num_phy_reinit,
           Retry_Threshold_hit, REINIT_Threshold_hit, retry_lrsm_state
  );
endinterface

// File: rtl/retry_timeout_timer.sv
// Saturating tick counter for the RETRY.Ack timeout; hit fires on a tick taken at max.
module retry_timeout_timer #(
  parameter int TMR_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             tick,
  input  logic [TMR_W-1:0] tmo_max,
  output logic             hit
);
  localparam logic [TMR_W-1:0] TMR_SAT = '1;

  logic [TMR_W-1:0] count;

  assign hit = tick && (count == tmo_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (tick && (count != TMR_SAT))
      count <= count + TMR_W'(1);
  end
endmodule

// File: rtl/retry_local_fsm.sv
// Local retry state machine: requests RETRY.Req on CRC errors, times out missing acks,
// escalates to PHY re-init and finally to a sticky link failure.
module retry_local_fsm
  import retry_pkg::*;
#(
  parameter int         CNT_W         = CNT_W_DEF,
  parameter int         TMR_W         = TMR_W_DEF,
  parameter logic [3:0] PL_ACTIVE_STS = PL_ACTIVE_STS_DEF
) (
  input logic               i_clk,
  input logic               i_rst_n,
  retry_local_fsm_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  lrsm_state_e      state, state_nxt;
  logic [CNT_W-1:0] num_retry, num_retry_nxt, num_reinit, num_reinit_nxt;
  logic             seen_low, seen_low_nxt;
  logic             send_q, send_nxt, prq_q, prq_nxt, fail_q, fail_nxt, dis_q, dis_nxt;
  logic             rhit_q, rhit_nxt, ihit_q, ihit_nxt;
  logic             crc_err, retry_exh, reinit_exh, tmr_clr, tmr_en, tmr_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign crc_err    = bus.unpacker_valid_sig && !bus.unpacker_valid_crc;
  assign retry_exh  = num_retry  >= bus.i_register_file_retry_threshold;
  assign reinit_exh = num_reinit >= bus.i_register_file_reinit_threshold;
  assign tmr_en     = (state == IDLE) && bus.controller_inc_time_out_retry;

  retry_timeout_timer #(.TMR_W(TMR_W)) u_timer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr     (tmr_clr),
    .tick    (tmr_en),
    .tmo_max (bus.i_register_file_retry_timeout_max_transfers),
    .hit     (tmr_hit)
  );

  always_comb begin
    state_nxt      = state;
    num_retry_nxt  = num_retry;
    num_reinit_nxt = num_reinit;
    seen_low_nxt   = seen_low;
    tmr_clr        = 1'b1;
    send_nxt       = 1'b0;
    prq_nxt        = 1'b0;
    fail_nxt       = 1'b0;
    dis_nxt        = (state != NORMAL);
    rhit_nxt       = 1'b0;
    ihit_nxt       = 1'b0;
    case (state)
      NORMAL: begin
        if (crc_err) state_nxt = LLRREQ;
      end
      LLRREQ: begin
        if (retry_exh) begin
          if (reinit_exh) begin
            state_nxt = ABORT;
            ihit_nxt  = 1'b1;
          end else begin
            state_nxt      = PHY_REINIT;
            rhit_nxt       = 1'b1;
            num_reinit_nxt = sat_inc(num_reinit);
            num_retry_nxt  = '0;
            seen_low_nxt   = 1'b0;
          end
        end else begin
          send_nxt = 1'b1;
          if (bus.controller_req_sent_flag) begin
            num_retry_nxt = sat_inc(num_retry);
            state_nxt     = IDLE;
          end
        end
      end
      IDLE: begin
        tmr_clr = 1'b0;
        // A same-cycle ack beats the timeout; CRC errors here are deliberately ignored.
        if (bus.unpacker_ack_seq_flag) begin
          state_nxt     = NORMAL;
          num_retry_nxt = '0;
          tmr_clr       = 1'b1;
        end else if (tmr_hit) begin
          state_nxt = LLRREQ;
        end
      end
      PHY_REINIT: begin
        prq_nxt = 1'b1;
        // Only a link that actually dropped and came back ACTIVE counts as re-initialised.
        if (!bus.i_pl_lnk_up)
          seen_low_nxt = 1'b1;
        else if (seen_low && (bus.i_pl_state_sts == PL_ACTIVE_STS))
          state_nxt = LLRREQ;
      end
      ABORT: begin
        fail_nxt = 1'b1;
      end
      default: state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= NORMAL;
      num_retry  <= '0;
      num_reinit <= '0;
      seen_low   <= 1'b0;
      send_q     <= 1'b0;
      prq_q      <= 1'b0;
      fail_q     <= 1'b0;
      dis_q      <= 1'b0;
      rhit_q     <= 1'b0;
      ihit_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      num_retry  <= num_retry_nxt;
      num_reinit <= num_reinit_nxt;
      seen_low   <= seen_low_nxt;
      send_q     <= send_nxt;
      prq_q      <= prq_nxt;
      fail_q     <= fail_nxt;
      dis_q      <= dis_nxt;
      rhit_q     <= rhit_nxt;
      ihit_q     <= ihit_nxt;
    end
  end

  assign bus.retry_send_req_seq     = send_q;
  assign bus.retry_phy_reinit_req   = prq_q;
  assign bus.retry_link_failure_sig = fail_q;
  assign bus.discard_received_flits = dis_q;
  assign bus.retry_num_retry        = num_retry;
  assign bus.retry_num_phy_reinit   = num_reinit;
  assign bus.Retry_Threshold_hit    = rhit_q;
  assign bus.REINIT_Threshold_hit   = ihit_q;
  assign bus.retry_lrsm_state       = state;
endmodule

// File: tb/tb_retry_local_fsm.sv
// Directed scoreboard bench for retry_local_fsm.
module tb_retry_local_fsm;
  import retry_pkg::*;

  localparam int CNT_W = 5;
  localparam int TMR_W = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  retry_local_fsm_if #(.CNT_W(CNT_W), .TMR_W(TMR_W)) ifc ();

  retry_local_fsm #(.CNT_W(CNT_W), .TMR_W(TMR_W), .PL_ACTIVE_STS(4'h1)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifc.slave)
  );

  // flags: {send_req, phy_reinit_req, link_fail, discard, retry_hit, reinit_hit}
  typedef struct packed {
    logic [2:0]       st;
    logic [5:0]       flags;
    logic [CNT_W-1:0] nr;
    logic [CNT_W-1:0] npr;
  } obs_t;

  obs_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic obs_t mk(input lrsm_state_e st, input logic [5:0] flags,
                              input logic [CNT_W-1:0] nr, input logic [CNT_W-1:0] npr);
    obs_t r;
    r.st = st; r.flags = flags; r.nr = nr; r.npr = npr;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.st    = ifc.retry_lrsm_state;
    r.flags = {ifc.retry_send_req_seq, ifc.retry_phy_reinit_req, ifc.retry_link_failure_sig,
               ifc.discard_received_flits, ifc.Retry_Threshold_hit, ifc.REINIT_Threshold_hit};
    r.nr    = ifc.retry_num_retry;
    r.npr   = ifc.retry_num_phy_reinit;
    return r;
  endfunction

  task automatic compare(input string tag);
    obs_t e, o;
    e = sb.pop_front();
    o = sample();
    n_run++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed st=%0d flags=%b nr=%0d npr=%0d, expected st=%0d flags=%b nr=%0d npr=%0d",
             tag, o.st, o.flags, o.nr, o.npr, e.st, e.flags, e.nr, e.npr);
    end
  endtask

  // in = {crc_err, ack, req_sent, tick}; flits are always valid, CRC bad only when crc_err
  task automatic step(input logic [3:0] in, input obs_t e, input string tag);
    ifc.unpacker_valid_sig            = 1'b1;
    ifc.unpacker_valid_crc            = ~in[3];
    ifc.unpacker_ack_seq_flag         = in[2];
    ifc.controller_req_sent_flag      = in[1];
    ifc.controller_inc_time_out_retry = in[0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    ifc.i_pl_lnk_up                   = 1'b1;
    ifc.i_pl_state_sts                = 4'h1;
    ifc.unpacker_valid_sig            = 1'b0;
    ifc.unpacker_valid_crc            = 1'b1;
    ifc.unpacker_ack_seq_flag         = 1'b0;
    ifc.controller_req_sent_flag      = 1'b0;
    ifc.controller_inc_time_out_retry = 1'b0;
    ifc.i_register_file_retry_threshold             = 5'd3;
    ifc.i_register_file_reinit_threshold            = 5'd3;
    ifc.i_register_file_retry_timeout_max_transfers = 13'd100;

    step(4'b0000, mk(NORMAL, 6'b000000, 5'd0, 5'd0), "reset_state");
    rst_n = 1'b1;

    // clean traffic, then a single retry answered by an ack
    for (int i = 0; i < 3; i++) step(4'b0000, mk(NORMAL, 6'b000000, 5'd0, 5'd0), "clean_flits");
    step(4'b1000, mk(LLRREQ, 6'b000000, 5'd0, 5'd0), "crc_to_llrreq");
    step(4'b0000, mk(LLRREQ, 6'b100100, 5'd0, 5'd0), "req_high_1");
    step(4'b0000, mk(LLRREQ, 6'b100100, 5'd0, 5'd0), "req_high_2");
    step(4'b0010, mk(IDLE,   6'b100100, 5'd1, 5'd0), "req_sent");
    step(4'b0000, mk(IDLE,   6'b000100, 5'd1, 5'd0), "req_dropped");
    step(4'b1000, mk(IDLE,   6'b000100, 5'd1, 5'd0), "crc_ignored_idle");
    for (int i = 0; i < 3; i++) step(4'b0000, mk(IDLE, 6'b000100, 5'd1, 5'd0), "idle_wait");
    step(4'b0100, mk(NORMAL, 6'b000100, 5'd0, 5'd0), "ack_to_normal");
    step(4'b0000, mk(NORMAL, 6'b000000, 5'd0, 5'd0), "normal_quiet");

    // two timeouts exhaust retry_thr=2, escalate to PHY re-init
    ifc.i_register_file_retry_threshold             = 5'd2;
    ifc.i_register_file_retry_timeout_max_transfers = 13'd4;
    step(4'b1000, mk(LLRREQ, 6'b000000, 5'd0, 5'd0), "crc_2");
    step(4'b0010, mk(IDLE,   6'b100100, 5'd1, 5'd0), "req_sent_2a");
    for (int i = 0; i < 4; i++) step(4'b0001, mk(IDLE, 6'b000100, 5'd1, 5'd0), "tick_a");
    step(4'b0001, mk(LLRREQ, 6'b000100, 5'd1, 5'd0), "timeout_1");
    step(4'b0010, mk(IDLE,   6'b100100, 5'd2, 5'd0), "req_sent_2b");
    for (int i = 0; i < 4; i++) step(4'b0001, mk(IDLE, 6'b000100, 5'd2, 5'd0), "tick_b");
    step(4'b0001, mk(LLRREQ, 6'b000100, 5'd2, 5'd0), "timeout_2");
    step(4'b0000, mk(PHY_REINIT, 6'b000110, 5'd0, 5'd1), "retry_thr_hit");
    step(4'b0000, mk(PHY_REINIT, 6'b010100, 5'd0, 5'd1), "reinit_req");
    ifc.i_pl_lnk_up = 1'b0;
    step(4'b0000, mk(PHY_REINIT, 6'b010100, 5'd0, 5'd1), "link_down");
    ifc.i_pl_lnk_up    = 1'b1;
    ifc.i_pl_state_sts = 4'h0;
    step(4'b0000, mk(PHY_REINIT, 6'b010100, 5'd0, 5'd1), "sts_not_active");
    ifc.i_pl_state_sts = 4'h1;
    step(4'b0000, mk(LLRREQ, 6'b010100, 5'd0, 5'd1), "reinit_done");
    step(4'b0000, mk(LLRREQ, 6'b100100, 5'd0, 5'd1), "req_after_reinit");
    step(4'b0010, mk(IDLE,   6'b100100, 5'd1, 5'd1), "req_sent_3");

    // ack and timeout in the same cycle
    for (int i = 0; i < 4; i++) step(4'b0001, mk(IDLE, 6'b000100, 5'd1, 5'd1), "tick_c");
    step(4'b0101, mk(NORMAL, 6'b000100, 5'd0, 5'd1), "ack_beats_timeout");
    step(4'b0000, mk(NORMAL, 6'b000000, 5'd0, 5'd1), "normal_after_tie");

    // reinit_thr=1 already reached: next exhaustion aborts
    ifc.i_register_file_retry_threshold  = 5'd1;
    ifc.i_register_file_reinit_threshold = 5'd1;
    step(4'b1000, mk(LLRREQ, 6'b000000, 5'd0, 5'd1), "crc_4");
    step(4'b0010, mk(IDLE,   6'b100100, 5'd1, 5'd1), "req_sent_4");
    for (int i = 0; i < 4; i++) step(4'b0001, mk(IDLE, 6'b000100, 5'd1, 5'd1), "tick_d");
    step(4'b0001, mk(LLRREQ, 6'b000100, 5'd1, 5'd1), "timeout_4");
    step(4'b0000, mk(ABORT,  6'b000101, 5'd1, 5'd1), "reinit_thr_hit");
    step(4'b0000, mk(ABORT,  6'b001100, 5'd1, 5'd1), "link_failure");
    step(4'b1110, mk(ABORT,  6'b001100, 5'd1, 5'd1), "abort_sticky_1");
    step(4'b0001, mk(ABORT,  6'b001100, 5'd1, 5'd1), "abort_sticky_2");
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(NORMAL, 6'b000000, 5'd0, 5'd0));
    compare("abort_cleared_by_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // retry threshold 0 escalates on first LLRREQ
    ifc.i_register_file_retry_threshold  = 5'd0;
    ifc.i_register_file_reinit_threshold = 5'd3;
    step(4'b1000, mk(LLRREQ, 6'b000000, 5'd0, 5'd0), "crc_thr0");
    step(4'b0000, mk(PHY_REINIT, 6'b000110, 5'd0, 5'd1), "thr0_escalate");

    // asynchronous reset while waiting in IDLE
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ifc.i_register_file_retry_threshold = 5'd3;
    step(4'b1000, mk(LLRREQ, 6'b000000, 5'd0, 5'd0), "crc_5");
    step(4'b0010, mk(IDLE,   6'b100100, 5'd1, 5'd0), "req_sent_5");
    step(4'b0001, mk(IDLE,   6'b000100, 5'd1, 5'd0), "idle_5");
    #3;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(NORMAL, 6'b000000, 5'd0, 5'd0));
    compare("reset_in_idle");
    step(4'b1000, mk(NORMAL, 6'b000000, 5'd0, 5'd0), "held_in_reset");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
